// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg: shared types and width defaults for the data RAM arbiter
// Revision 1.0
// ============================================================================
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 16;

    typedef enum logic [0:0] {ARB, HOST_BURST} arb_state_t;

    typedef enum {SRC_NONE, SRC_CPU, SRC_HOST} src_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter: CPU/host arbiter with starvation counter and bounded host burst
// Revision 1.0
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [WAIT_W-1:0]  c_wait_max  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] c_burst_max = BURST_W'(BURST_MAX);

    arb_state_t         r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic               r_cpu_prio;
    src_t               r_rd_src;

    arb_state_t         w_state_nxt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic [BURST_W-1:0] w_burst_nxt;
    logic               w_prio_nxt;
    src_t               w_src_nxt;
    logic               w_cpu_win;
    logic               w_host_win;

    always_comb begin
        w_cpu_win   = 1'b0;
        w_host_win  = 1'b0;
        w_state_nxt = r_state;
        w_burst_nxt = '0;
        w_prio_nxt  = 1'b0;
        w_wait_nxt  = r_wait_cnt;
        w_src_nxt   = SRC_NONE;
        mem_addr    = '0;
        mem_wr      = 1'b0;
        mem_wdata   = '0;

        case (r_state)
            ARB: begin
                // r_cpu_prio gives the CPU one guaranteed slot right after a host burst
                w_host_win = host_req &&
                             (!cpu_req || ((r_wait_cnt == c_wait_max) && !r_cpu_prio));
                w_cpu_win  = cpu_req && !w_host_win;
                if (w_host_win && host_lock) begin
                    w_state_nxt = HOST_BURST;
                    w_burst_nxt = BURST_W'(1);
                end
            end
            HOST_BURST: begin
                w_host_win  = host_req;
                w_burst_nxt = r_burst_cnt + BURST_W'(host_req);
                if (!host_lock || !host_req || (w_burst_nxt == c_burst_max)) begin
                    w_state_nxt = ARB;
                    w_burst_nxt = '0;
                    w_prio_nxt  = cpu_req;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase

        if (!Reset) begin
            w_cpu_win  = 1'b0;
            w_host_win = 1'b0;
        end

        if (!host_req || w_host_win) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt != c_wait_max) begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end

        if (w_cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wr    = cpu_wr;
            mem_wdata = cpu_wdata;
            w_src_nxt = cpu_wr ? SRC_NONE : SRC_CPU;
        end else if (w_host_win) begin
            mem_addr  = host_addr;
            mem_wr    = host_wr;
            mem_wdata = host_wdata;
            w_src_nxt = host_wr ? SRC_NONE : SRC_HOST;
        end

        cpu_gnt  = w_cpu_win;
        host_gnt = w_host_win;
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state     <= ARB;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
            r_cpu_prio  <= 1'b0;
            r_rd_src    <= SRC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_cpu_prio  <= w_prio_nxt;
            r_rd_src    <= w_src_nxt;
        end
    end

    // Gating by Reset drops a read that was in flight when reset arrived
    assign cpu_rvalid  = Reset && (r_rd_src == SRC_CPU);
    assign host_rvalid = Reset && (r_rd_src == SRC_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a behavioural RAM
// Revision 1.0
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        Reset;
    logic        cpu_req, cpu_wr;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        host_req, host_wr, host_lock;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic [7:0]  mem_addr;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:255];
    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_h;
    logic        exp_c;
    int          h_done;

    dmem_arbiter dut (
        .clk         (clk),
        .Reset       (Reset),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_wr     (host_wr),
        .host_lock   (host_lock),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req    = 1'b0;
        cpu_wr     = 1'b0;
        cpu_addr   = 8'h00;
        cpu_wdata  = 16'h0000;
        host_req   = 1'b0;
        host_wr    = 1'b0;
        host_lock  = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        Reset = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h33;
        host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h44;

        for (int i = 0; i < 2; i++) begin
            #2;
            chk("rst_cpu_gnt",     32'(cpu_gnt),     32'd0);
            chk("rst_host_gnt",    32'(host_gnt),    32'd0);
            chk("rst_mem_wr",      32'(mem_wr),      32'd0);
            chk("rst_cpu_rvalid",  32'(cpu_rvalid),  32'd0);
            chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
            tick();
        end
        Reset = 1'b1;
        #2;
        chk("rel_cpu_gnt",  32'(cpu_gnt),  32'd1);
        chk("rel_host_gnt", 32'(host_gnt), 32'd0);
        tick();
        idle();
        tick();

        // CPU wins four times, the starved host takes the fifth slot
        cpu_req = 1'b1; cpu_addr = 8'h11;
        host_req = 1'b1; host_addr = 8'h22;
        for (int i = 0; i < 10; i++) begin
            #2;
            exp_h = ((i % 5) == 4);
            chk("cont_cpu_gnt",  32'(cpu_gnt),  32'(!exp_h));
            chk("cont_host_gnt", 32'(host_gnt), 32'(exp_h));
            chk("cont_mem_addr", 32'(mem_addr), exp_h ? 32'h22 : 32'h11);
            tick();
        end
        idle();

        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h6A; cpu_wdata = 16'hBEEF;
        #2;
        chk("pre_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        idle();
        tick();
        host_req = 1'b1; host_addr = 8'h6A;
        #2;
        chk("rd_host_gnt",    32'(host_gnt),    32'd1);
        chk("rd_host_rvalid0", 32'(host_rvalid), 32'd0);
        tick();
        idle();
        #2;
        chk("rd_host_rvalid", 32'(host_rvalid), 32'd1);
        chk("rd_host_rdata",  32'(host_rdata),  32'hBEEF);
        chk("rd_cpu_rvalid",  32'(cpu_rvalid),  32'd0);
        tick();
        #2;
        chk("rd_host_rvalid_end", 32'(host_rvalid), 32'd0);
        chk("rd_host_rdata_end",  32'(host_rdata),  32'd0);
        tick();

        // Locked host burst: 8 grants, one CPU slot, then the host finishes
        h_done = 0;
        host_wr = 1'b1; host_lock = 1'b1;
        for (int c = 0; c < 11; c++) begin
            host_req   = (h_done < 10);
            host_addr  = 8'(128 + h_done);
            host_wdata = 16'(16'h00A0 + h_done);
            cpu_req    = (c >= 1) && (c <= 8);
            cpu_addr   = 8'h05;
            #2;
            exp_c = (c == 8);
            chk("burst_cpu_gnt",  32'(cpu_gnt),  32'(exp_c));
            chk("burst_host_gnt", 32'(host_gnt), 32'(!exp_c));
            if (!exp_c) h_done++;
            tick();
        end
        idle();
        chk("burst_first_write", 32'(ram[8'h80]), 32'h00A0);
        chk("burst_last_write",  32'(ram[8'h89]), 32'h00A9);
        tick();

        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'h1234;
        #2;
        chk("wr_cpu_gnt",   32'(cpu_gnt),   32'd1);
        chk("wr_mem_wr",    32'(mem_wr),    32'd1);
        chk("wr_mem_addr",  32'(mem_addr),  32'h05);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        cpu_wr = 1'b0;
        #2;
        chk("rd_mem_wr",  32'(mem_wr),  32'd0);
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        idle();
        #2;
        chk("wr_rd_cpu_rvalid",  32'(cpu_rvalid),  32'd1);
        chk("wr_rd_cpu_rdata",   32'(cpu_rdata),   32'h1234);
        chk("wr_rd_host_rvalid", 32'(host_rvalid), 32'd0);
        tick();

        cpu_req = 1'b1; cpu_addr = 8'h05;
        #2;
        chk("mid_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        idle();
        Reset = 1'b0;
        #2;
        chk("mid_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("mid_cpu_rdata",  32'(cpu_rdata),  32'd0);
        tick();
        Reset = 1'b1;
        #2;
        chk("mid_cpu_rvalid_after", 32'(cpu_rvalid), 32'd0);
        tick();

        // Reset during a host burst must return to ARB, where the CPU wins a tie
        host_req = 1'b1; host_lock = 1'b1; host_addr = 8'h6A;
        #2;
        chk("brst_host_gnt", 32'(host_gnt), 32'd1);
        tick();
        Reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 8'h05;
        #2;
        chk("brst_rst_host_gnt", 32'(host_gnt), 32'd0);
        chk("brst_rst_cpu_gnt",  32'(cpu_gnt),  32'd0);
        tick();
        Reset = 1'b1;
        #2;
        chk("brst_rel_cpu_gnt",     32'(cpu_gnt),     32'd1);
        chk("brst_rel_host_gnt",    32'(host_gnt),    32'd0);
        chk("brst_rel_host_rvalid", 32'(host_rvalid), 32'd0);
        tick();
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
